frame_accumulator: RTL and testbench

//  Upstream feeder for the frame-result stage. Collects a framed stream of
//  2-bit sample pairs (d1, d2), sums d1+d2 per beat into an 18-bit base value
//  and counts beats. At end of frame it presents {base, count, flags} to the

---
 rtl/frame_accumulator_if.sv | 31 +++
 rtl/frame_accumulator.sv | 163 ++++++++++++++++
 tb/tb_frame_accumulator.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_accumulator_if.sv
// Frame accumulator bus: input beat channel plus result channel.
// slave = the accumulator itself, master = whoever feeds beats and consumes results.
// Handshake: a beat transfers on a rising clk edge where in_valid & in_ready;
// a result transfers on a rising clk edge where out_valid & out_ready.
interface frame_accumulator_if #(
  parameter int BASE_W = 18,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_start;
  logic              in_end;
  logic [1:0]        d1;
  logic [1:0]        d2;
  logic              out_valid;
  logic              out_ready;
  logic [BASE_W-1:0] out_base;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              out_trunc;

  modport slave (
    input  in_valid, in_start, in_end, d1, d2, out_ready,
    output in_ready, out_valid, out_base, out_count, out_ovf, out_trunc
  );

  modport master (
    output in_valid, in_start, in_end, d1, d2, out_ready,
    input  in_ready, out_valid, out_base, out_count, out_ovf, out_trunc
  );
endinterface

// File: rtl/frame_accumulator.sv
// frame_accumulator: sums d1+d2 over a framed beat stream and counts beats,
// then holds {base, count, ovf, trunc} until the consumer takes it.
// Optional macro FRAME_ACC_SATURATE_EN: base clamps at all-ones instead of wrapping.
// State is visible on dbg_state (0=IDLE, 1=ACCUM, 2=HOLD).
module frame_accumulator #(
  parameter int BASE_W  = 18,
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  frame_accumulator_if.slave   bus,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              trunc_q, trunc_d;
  logic              err_q, err_d;
  logic              skip_q, skip_d;       // drop stray beats after a truncated frame
  logic              out_valid_q, out_valid_d;

  logic              in_ready;
  logic              accept;
  logic              first_beat;
  logic              open_frame;
  logic [2:0]        term3;
  logic [BASE_W-1:0] term;
  logic [BASE_W:0]   sum;
  logic [BASE_W-1:0] add_base;
  logic              add_ovf;
  logic [CNT_W-1:0]  count_inc;

  assign in_ready   = (state_q != HOLD);
  assign accept     = bus.in_valid & in_ready;
  assign term3      = {1'b0, bus.d1} + {1'b0, bus.d2};
  assign term       = BASE_W'(term3);
  // A beat that opens a frame adds onto zero rather than the stale base.
  assign first_beat = (state_q == IDLE) | bus.in_start;
  assign sum        = {1'b0, (first_beat ? {BASE_W{1'b0}} : base_q)} + {1'b0, term};
  assign count_inc  = count_q + ONE_CNT;

`ifdef FRAME_ACC_SATURATE_EN
  assign add_base = sum[BASE_W] ? {BASE_W{1'b1}} : sum[BASE_W-1:0];
  assign add_ovf  = sum[BASE_W];
`else
  assign add_base = sum[BASE_W-1:0];
  assign add_ovf  = sum[BASE_W];
`endif

  // Next-state and datapath update for the IDLE/ACCUM/HOLD frame FSM.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    trunc_d     = trunc_q;
    err_d       = err_q;
    skip_d      = skip_q;
    open_frame  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_start) begin
            open_frame = 1'b1;
          end else if (!skip_q) begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (bus.in_start) begin
            // restart: partial frame thrown away, this beat becomes the first
            open_frame = 1'b1;
            err_d      = 1'b1;
          end else begin
            base_d  = add_base;
            count_d = count_inc;
            ovf_d   = ovf_q | add_ovf;
            if (bus.in_end) begin
              state_d = HOLD;
            end else if (count_inc == MAX_CNT) begin
              state_d = HOLD;
              trunc_d = 1'b1;
              skip_d  = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (open_frame) begin
      base_d  = add_base;
      count_d = ONE_CNT;
      ovf_d   = add_ovf;
      trunc_d = 1'b0;
      skip_d  = 1'b0;
      if (bus.in_end) begin
        state_d = HOLD;
      end else if (ONE_CNT == MAX_CNT) begin
        state_d = HOLD;
        trunc_d = 1'b1;
        skip_d  = 1'b1;
      end else begin
        state_d = ACCUM;
      end
    end

    out_valid_d = (state_d == HOLD);
  end

  // State and result registers; reset drops any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      trunc_q     <= 1'b0;
      err_q       <= 1'b0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      trunc_q     <= trunc_d;
      err_q       <= err_d;
      skip_q      <= skip_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_base  = base_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_trunc = trunc_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench for frame_accumulator: default build, a MAX_LEN=4 build and
// a BASE_W=4 build share one stimulus bus; sel picks the instance under check.
module tb_frame_accumulator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_start = 1'b0;
  logic       in_end   = 1'b0;
  logic [1:0] d1       = 2'd0;
  logic [1:0] d2       = 2'd0;
  logic       out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int sel    = 0;   // 0 = main, 1 = trunc (MAX_LEN=4), 2 = wrap (BASE_W=4)

  frame_accumulator_if #(.BASE_W(18), .CNT_W(8)) if_main ();
  frame_accumulator_if #(.BASE_W(18), .CNT_W(8)) if_trunc ();
  frame_accumulator_if #(.BASE_W(4),  .CNT_W(8)) if_wrap ();

  assign if_main.in_valid  = in_valid;
  assign if_main.in_start  = in_start;
  assign if_main.in_end    = in_end;
  assign if_main.d1        = d1;
  assign if_main.d2        = d2;
  assign if_main.out_ready = out_ready;
  assign if_trunc.in_valid  = in_valid;
  assign if_trunc.in_start  = in_start;
  assign if_trunc.in_end    = in_end;
  assign if_trunc.d1        = d1;
  assign if_trunc.d2        = d2;
  assign if_trunc.out_ready = out_ready;
  assign if_wrap.in_valid  = in_valid;
  assign if_wrap.in_start  = in_start;
  assign if_wrap.in_end    = in_end;
  assign if_wrap.d1        = d1;
  assign if_wrap.d2        = d2;
  assign if_wrap.out_ready = out_ready;

  logic       err_main, err_trunc, err_wrap;
  logic [1:0] dbg_main, dbg_trunc, dbg_wrap;

  frame_accumulator #(.BASE_W(18), .CNT_W(8), .MAX_LEN(255)) u_main (
    .clk(clk), .reset_n(reset_n), .bus(if_main), .err(err_main), .dbg_state(dbg_main)
  );
  frame_accumulator #(.BASE_W(18), .CNT_W(8), .MAX_LEN(4)) u_trunc (
    .clk(clk), .reset_n(reset_n), .bus(if_trunc), .err(err_trunc), .dbg_state(dbg_trunc)
  );
  frame_accumulator #(.BASE_W(4), .CNT_W(8), .MAX_LEN(255)) u_wrap (
    .clk(clk), .reset_n(reset_n), .bus(if_wrap), .err(err_wrap), .dbg_state(dbg_wrap)
  );

  // selected instance outputs
  logic        s_in_ready, s_out_valid, s_ovf, s_trunc, s_err;
  logic [17:0] s_base;
  logic [7:0]  s_count;
  logic [1:0]  s_state;

  always_comb begin
    s_in_ready  = if_main.in_ready;
    s_out_valid = if_main.out_valid;
    s_base      = if_main.out_base;
    s_count     = if_main.out_count;
    s_ovf       = if_main.out_ovf;
    s_trunc     = if_main.out_trunc;
    s_err       = err_main;
    s_state     = dbg_main;
    if (sel == 1) begin
      s_in_ready  = if_trunc.in_ready;
      s_out_valid = if_trunc.out_valid;
      s_base      = if_trunc.out_base;
      s_count     = if_trunc.out_count;
      s_ovf       = if_trunc.out_ovf;
      s_trunc     = if_trunc.out_trunc;
      s_err       = err_trunc;
      s_state     = dbg_trunc;
    end else if (sel == 2) begin
      s_in_ready  = if_wrap.in_ready;
      s_out_valid = if_wrap.out_valid;
      s_base      = {14'd0, if_wrap.out_base};
      s_count     = if_wrap.out_count;
      s_ovf       = if_wrap.out_ovf;
      s_trunc     = if_wrap.out_trunc;
      s_err       = err_wrap;
      s_state     = dbg_wrap;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // offer one beat; waits (bounded) for in_ready, then lets it transfer
  task automatic send_beat(input logic st, input logic en, input logic [1:0] a, input logic [1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_start = st; in_end = en; d1 = a; d2 = b;
    while (!s_in_ready && n < 50) begin
      step();
      n++;
    end
    check_val("beat_ready", s_in_ready, 1);
    step();
    in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] base, input logic [31:0] cnt,
                              input logic [31:0] ovf, input logic [31:0] trunc);
    check_val({tag, "_valid"}, s_out_valid, 1);
    check_val({tag, "_base"},  s_base, base);
    check_val({tag, "_count"}, s_count, cnt);
    check_val({tag, "_ovf"},   s_ovf, ovf);
    check_val({tag, "_trunc"}, s_trunc, trunc);
  endtask

  initial begin
    // ---- 1: reset mid-ACCUM ----
    sel = 0;
    do_reset();
    out_ready = 1'b0;
    send_beat(1'b1, 1'b0, 2'd1, 2'd1);
    send_beat(1'b0, 1'b0, 2'd2, 2'd1);
    check_val("pre_rst_state", s_state, 1);
    check_val("pre_rst_count", s_count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_in_ready", s_in_ready, 1);
    check_val("rst_out_valid", s_out_valid, 0);
    check_val("rst_base", s_base, 0);
    check_val("rst_count", s_count, 0);
    check_val("rst_ovf", s_ovf, 0);
    check_val("rst_trunc", s_trunc, 0);
    check_val("rst_err", s_err, 0);
    check_val("rst_state", s_state, 0);
    step();
    reset_n = 1'b1;

    // ---- 2: three-beat frame, held with out_ready=0 ----
    out_ready = 1'b0;
    send_beat(1'b1, 1'b0, 2'd1, 2'd2);
    send_beat(1'b0, 1'b0, 2'd3, 2'd3);
    check_val("f3_not_yet_valid", s_out_valid, 0);
    send_beat(1'b0, 1'b1, 2'd0, 2'd1);
    check_result("f3", 10, 3, 0, 0);
    check_val("f3_in_ready", s_in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("f3_hold_valid", s_out_valid, 1);
      check_val("f3_hold_base", s_base, 10);
      check_val("f3_hold_count", s_count, 3);
    end
    out_ready = 1'b1;
    step();
    check_val("f3_release_valid", s_out_valid, 0);
    check_val("f3_release_ready", s_in_ready, 1);

    // ---- 3: single beat start&end ----
    send_beat(1'b1, 1'b1, 2'd3, 2'd3);
    check_result("f1", 6, 1, 0, 0);
    step();
    check_val("f1_drop_valid", s_out_valid, 0);

    // ---- 4: MAX_LEN=4 truncation ----
    sel = 1;
    do_reset();
    out_ready = 1'b1;
    send_beat(1'b1, 1'b0, 2'd1, 2'd1);
    for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 2'd1, 2'd1);
    check_result("trunc", 8, 4, 0, 1);
    send_beat(1'b0, 1'b0, 2'd1, 2'd1);
    send_beat(1'b0, 1'b0, 2'd1, 2'd1);
    step();
    check_val("trunc_drop_err", s_err, 0);
    check_val("trunc_drop_valid", s_out_valid, 0);
    check_val("trunc_drop_state", s_state, 0);
    send_beat(1'b1, 1'b1, 2'd2, 2'd0);
    check_result("trunc_next", 2, 1, 0, 0);
    step();

    // ---- 5: protocol errors ----
    sel = 0;
    do_reset();
    check_val("err_clear", s_err, 0);
    out_ready = 1'b0;
    send_beat(1'b0, 1'b0, 2'd1, 2'd1);
    check_val("err_stray", s_err, 1);
    check_val("err_stray_state", s_state, 0);
    send_beat(1'b1, 1'b0, 2'd2, 2'd2);
    send_beat(1'b0, 1'b0, 2'd1, 2'd0);
    send_beat(1'b1, 1'b0, 2'd3, 2'd0);
    send_beat(1'b0, 1'b1, 2'd0, 2'd2);
    check_result("restart", 5, 2, 0, 0);
    check_val("restart_err", s_err, 1);
    out_ready = 1'b1;
    step();
    send_beat(1'b1, 1'b1, 2'd1, 2'd1);
    check_result("after_err", 2, 1, 0, 0);
    check_val("err_sticky", s_err, 1);
    step();

    // ---- 6: BASE_W=4 overflow ----
    sel = 2;
    do_reset();
    out_ready = 1'b0;
    send_beat(1'b1, 1'b0, 2'd3, 2'd3);
    send_beat(1'b0, 1'b0, 2'd3, 2'd3);
    send_beat(1'b0, 1'b1, 2'd3, 2'd3);
`ifdef FRAME_ACC_SATURATE_EN
    check_result("ovf", 15, 3, 1, 0);
`else
    check_result("ovf", 2, 3, 1, 0);
`endif
    out_ready = 1'b1;
    step();
    send_beat(1'b1, 1'b1, 2'd0, 2'd1);
    check_result("ovf_cleared", 1, 1, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
